// File: rtl/vec_ctrl_pkg.sv
// Shared definitions for the vector sequencer.
// Opcodes, FSM states and instruction field helpers.
package vec_ctrl_pkg;

  localparam int OPC_LSB = 13;
  localparam int REG_LSB = 11;
  localparam int TMR_W   = 16;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_STORE = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;
  localparam logic [2:0] OP_MUL   = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MEM_RD,
    ST_MEM_WR,
    ST_ALU_START,
    ST_ALU_WAIT,
    ST_DONE
  } state_e;

  function automatic logic [2:0] opc_of(
    input logic [15:0] ins
  );
    return ins[OPC_LSB+:3];
  endfunction

  function automatic logic [1:0] reg_of(
    input logic [15:0] ins
  );
    return ins[REG_LSB+:2];
  endfunction

endpackage

// File: rtl/vec_ctrl_watchdog.sv
// Wait-cycle counter for the vector sequencer.
// Flags expiry on the TIMEOUT-th consecutive stalled cycle.
module vec_ctrl_watchdog
  import vec_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [TMR_W-1:0] LAST =
    TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i & (cnt_q == LAST);

endmodule

// File: rtl/vec_ctrl.sv
// Single-issue sequencer for the 4x512b vector register file.
// Drives memory, ALU and register-file strobes for one instruction.
module vec_ctrl
  import vec_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_rsel,
  input  logic              mem_ack,
  output logic              alu_start,
  output logic              alu_op,
  input  logic              alu_done,
  output logic              rf_write_enable,
  output logic [1:0]        rf_write_select,
  output logic              rf_write_enable_alu,
  output logic              instr_done,
  output logic              err,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [2:0]        opc_q, opc_d;
  logic [1:0]        reg_q, reg_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;

  logic in_mem, in_wait, hit, expire;
  logic rfwe, rfwe_alu;
  logic [1:0] rfsel;

  if (ADDR_W < 11) begin : g_pad
    logic unused_bits;
    assign unused_bits = ^instr[10:ADDR_W];
  end

  assign in_mem  = (state_q == ST_MEM_RD) ||
                   (state_q == ST_MEM_WR);
  assign in_wait = in_mem ||
                   (state_q == ST_ALU_WAIT);
  assign hit = (in_mem & mem_ack) |
               ((state_q == ST_ALU_WAIT) & alu_done);

  vec_ctrl_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (~in_wait),
    .en_i    (in_wait & ~hit),
    .expire_o(expire)
  );

  always_comb begin
    state_d  = state_q;
    opc_d    = opc_q;
    reg_d    = reg_q;
    addr_d   = addr_q;
    err_d    = err_q;
    rfwe     = 1'b0;
    rfsel    = 2'd0;
    rfwe_alu = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          opc_d  = opc_of(instr);
          reg_d  = reg_of(instr);
          addr_d = instr[ADDR_W-1:0];
          unique case (opc_of(instr))
            OP_NOP:   state_d = ST_DONE;
            OP_LOAD:  state_d = ST_MEM_RD;
            OP_STORE: state_d = ST_MEM_WR;
            OP_ADD,
            OP_MUL:   state_d = ST_ALU_START;
            default: begin
              err_d   = 1'b1;
              state_d = ST_DONE;
            end
          endcase
        end
      end
      ST_MEM_RD, ST_MEM_WR: begin
        if (mem_ack) begin
          rfwe    = (state_q == ST_MEM_RD);
          rfsel   = rfwe ? reg_q : 2'd0;
          state_d = ST_DONE;
        end else if (expire) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_ALU_START: state_d = ST_ALU_WAIT;
      ST_ALU_WAIT: begin
        if (alu_done) begin
          rfwe_alu = 1'b1;
          state_d  = ST_DONE;
        end else if (expire) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      opc_q   <= OP_NOP;
      reg_q   <= 2'd0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      reg_q   <= reg_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  // Every output is forced low while rst is asserted.
  assign instr_ready = ~rst & (state_q == ST_IDLE);
  assign busy        = ~rst & (state_q != ST_IDLE);
  assign mem_req     = ~rst & in_mem;
  assign mem_we      = ~rst & (state_q == ST_MEM_WR);
  assign mem_addr    = mem_req ? addr_q : '0;
  assign mem_rsel    = mem_we ? reg_q : 2'd0;
  assign alu_start   = ~rst & (state_q == ST_ALU_START);
  assign alu_op      = ~rst & (opc_q == OP_MUL) &
                       ((state_q == ST_ALU_START) ||
                        (state_q == ST_ALU_WAIT));
  assign instr_done  = ~rst & (state_q == ST_DONE);
  assign err         = instr_done & err_q;

  assign rf_write_enable     = ~rst & rfwe;
  assign rf_write_select     = rst ? 2'd0 : rfsel;
  assign rf_write_enable_alu = ~rst & rfwe_alu;

endmodule

// File: tb/tb_vec_ctrl.sv
// Directed bench for vec_ctrl with a short watchdog.
// Inputs change 2ns after posedge, outputs sampled 1ns later.
module tb_vec_ctrl;

  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          iv;
  logic          ready;
  logic [15:0]   ins;
  logic          req, we;
  logic [AW-1:0] addr;
  logic [1:0]    rsel;
  logic          ack;
  logic          astart, aop, adone;
  logic          rfwe;
  logic [1:0]    rfsel;
  logic          rfwea;
  logic          done, err, busy;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  vec_ctrl #(
    .ADDR_W (AW),
    .TIMEOUT(8)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .instr_valid        (iv),
    .instr_ready        (ready),
    .instr              (ins),
    .mem_req            (req),
    .mem_we             (we),
    .mem_addr           (addr),
    .mem_rsel           (rsel),
    .mem_ack            (ack),
    .alu_start          (astart),
    .alu_op             (aop),
    .alu_done           (adone),
    .rf_write_enable    (rfwe),
    .rf_write_select    (rfsel),
    .rf_write_enable_alu(rfwea),
    .instr_done         (done),
    .err                (err),
    .busy               (busy)
  );

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(
    input string       tag,
    input logic [15:0] obs,
    input logic [15:0] exp
  );
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; iv = 1'b0; ins = 16'h0;
    ack = 1'b0; adone = 1'b0;
    cyc(); #1;
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    cyc(); rst = 1'b0; #1;
    chk("idle_ready", ready, 1);

    // LOAD A3, addr 5, ack on third wait cycle
    iv = 1'b1; ins = 16'h3005; #1;
    cyc(); iv = 1'b0; #1;
    chk("ld_req1", req, 1);
    chk("ld_addr", addr, 5);
    chk("ld_we", we, 0);
    chk("ld_ready", ready, 0);
    cyc(); #1;
    chk("ld_req2", req, 1);
    chk("ld_rfwe2", rfwe, 0);
    cyc(); ack = 1'b1; #1;
    chk("ld_req3", req, 1);
    chk("ld_rfwe", rfwe, 1);
    chk("ld_rfsel", rfsel, 2);
    chk("ld_rfwea", rfwea, 0);
    cyc(); ack = 1'b0; #1;
    chk("ld_done", done, 1);
    chk("ld_err", err, 0);
    chk("ld_req_off", req, 0);
    cyc(); ack = 1'b1; #1;
    chk("idle_ack_ign", rfwe, 0);
    chk("idle_done", done, 0);

    // STORE A4, addr 4, immediate ack
    ack = 1'b0; iv = 1'b1; ins = 16'h5804;
    cyc(); iv = 1'b0; ack = 1'b1; #1;
    chk("st_req", req, 1);
    chk("st_we", we, 1);
    chk("st_rsel", rsel, 3);
    chk("st_addr", addr, 4);
    chk("st_rfwe", rfwe, 0);
    cyc(); ack = 1'b0; #1;
    chk("st_done", done, 1);
    chk("st_err", err, 0);

    // MUL, done 4 cycles after start
    cyc(); iv = 1'b1; ins = 16'h8000;
    cyc(); iv = 1'b0; adone = 1'b1; #1;
    chk("mul_start", astart, 1);
    chk("mul_op", aop, 1);
    chk("mul_early", rfwea, 0);
    cyc(); adone = 1'b0; #1;
    chk("mul_start_off", astart, 0);
    chk("mul_op_held", aop, 1);
    chk("mul_wait", done, 0);
    cyc(); #1;
    cyc(); #1;
    chk("mul_wait3", rfwea, 0);
    cyc(); adone = 1'b1; #1;
    chk("mul_rfwea", rfwea, 1);
    chk("mul_rfwe", rfwe, 0);
    cyc(); adone = 1'b0; #1;
    chk("mul_done", done, 1);
    chk("mul_err", err, 0);
    chk("mul_rfwea_off", rfwea, 0);

    // LOAD with no ack: watchdog after 8 cycles
    cyc(); iv = 1'b1; ins = 16'h2007;
    for (int i = 1; i <= 8; i++) begin
      cyc(); iv = 1'b0; #1;
      chk("to_req", req, 1);
      chk("to_rfwe", rfwe, 0);
    end
    cyc(); #1;
    chk("to_req_off", req, 0);
    chk("to_done", done, 1);
    chk("to_err", err, 1);
    chk("to_rfwe_end", rfwe, 0);

    // ack on the expiry cycle completes normally
    cyc(); iv = 1'b1; ins = 16'h2807;
    for (int i = 1; i <= 7; i++) begin
      cyc(); iv = 1'b0; #1;
    end
    cyc(); ack = 1'b1; #1;
    chk("tie_rfwe", rfwe, 1);
    chk("tie_rfsel", rfsel, 1);
    cyc(); ack = 1'b0; #1;
    chk("tie_done", done, 1);
    chk("tie_err", err, 0);

    // illegal opcode 111
    cyc(); iv = 1'b1; ins = 16'hE000;
    cyc(); iv = 1'b0; #1;
    chk("ill_done", done, 1);
    chk("ill_err", err, 1);
    cyc(); #1;
    chk("ill_ready", ready, 1);
    chk("ill_err_clr", err, 0);

    // NOP then ADD back-to-back
    iv = 1'b1; ins = 16'h0000;
    cyc(); ins = 16'h6000; #1;
    chk("nop_done", done, 1);
    chk("nop_ready", ready, 0);
    cyc(); #1;
    chk("add_accept", ready, 1);
    cyc(); iv = 1'b0; #1;
    chk("add_start", astart, 1);
    chk("add_op", aop, 0);
    cyc(); adone = 1'b1; #1;
    chk("add_rfwea", rfwea, 1);
    cyc(); adone = 1'b0; #1;
    chk("add_done", done, 1);

    // reset in the middle of a LOAD
    cyc(); iv = 1'b1; ins = 16'h3005;
    cyc(); iv = 1'b0; #1;
    chk("rm_req", req, 1);
    cyc(); rst = 1'b1; #1;
    chk("rm_rst_req", req, 0);
    chk("rm_rst_ready", ready, 0);
    cyc(); rst = 1'b0; ack = 1'b1; #1;
    chk("rm_ready", ready, 1);
    chk("rm_req_off", req, 0);
    chk("rm_ack_ign", rfwe, 0);
    chk("rm_nodone", done, 0);
    cyc(); ack = 1'b0; #1;
    chk("rm_busy", busy, 0);
    chk("rm_done2", done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
